// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder with a small IDLE/RUN/DONE controller. On an accepted
// start the operands are captured into shift registers and added LSB first,
// one bit per clock, through a single 1-bit full adder made from two
// half-adder stages and an OR. After WIDTH RUN cycles the result is loaded
// into the output registers and done pulses for one cycle.
//
// Parameters
//   WIDTH      operand width in bits (2..32)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a new addition (sampled only in IDLE)
//   a, b       operands, captured on the edge that accepts start
//   busy       high while in RUN
//   done       one-cycle pulse, high while in DONE
//   sum        registered (a + b) mod 2^WIDTH, held until the next DONE load
//   carry_out  registered carry out of the MSB
//   ovf        (only with SERIAL_ADD_OVF_EN) registered two's-complement
//              overflow: carry into MSB XOR carry out of MSB
//
// Build option
//   SERIAL_ADD_OVF_EN  when defined, adds the ovf output and its logic
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter must hold WIDTH itself so it never wraps within an operation.
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_load;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry_out;

    // -----------------------------------------------------------------------
    // 1-bit full adder: two half adders plus an OR of their carries
    // -----------------------------------------------------------------------
    logic             w_ha1_s;
    logic             w_ha1_c;
    logic             w_ha2_c;
    logic             w_fa_s;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_psum_nxt;

    assign w_ha1_s    = r_a_sh[0] ^ r_b_sh[0];
    assign w_ha1_c    = r_a_sh[0] & r_b_sh[0];
    assign w_fa_s     = w_ha1_s ^ r_carry;
    assign w_ha2_c    = w_ha1_s & r_carry;
    assign w_fa_c     = w_ha1_c | w_ha2_c;

    // Result bits enter at the MSB; after WIDTH shifts bit 0 is the LSB sum.
    assign w_psum_nxt = {w_fa_s, r_psum[WIDTH-1:1]};

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // start is ignored here; IDLE always follows.
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: operand shifters, partial sum, carry, counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_psum  <= w_psum_nxt;
            r_carry <= w_fa_c;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Result registers: loaded only on the final RUN edge, held otherwise
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else if (w_last) begin
            r_sum       <= w_psum_nxt;
            r_carry_out <= w_fa_c;
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_carry_out;

`ifdef SERIAL_ADD_OVF_EN
    // On the final RUN cycle r_carry is the carry into the MSB and w_fa_c
    // the carry out of it, so no separate capture register is needed.
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_fa_c;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl (WIDTH = 8). A table of operand
// pairs with constant expected results runs through the adder; expected
// results are queued when an operation is started and popped when done
// pulses. Hand-written sequences cover start while busy, reset mid-RUN,
// start on the first edge after reset and back-to-back operation with start
// held high. Build with SERIAL_ADD_OVF_EN to also check ovf.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sum;
        logic       co;
        logic       ovf;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       co;
        logic       ovf;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Compare the current outputs against the oldest queued expectation.
    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected done with sum=0x%0h", tag, sum);
            return;
        end
        e = sb.pop_front();
        check({tag, " sum"}, 32'(sum), 32'(e.sum));
        check({tag, " carry_out"}, 32'(carry_out), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    endtask

    // Called on a negedge after the accepting edge; walks negedges until
    // done, counting busy cycles and watching that sum holds during RUN.
    task automatic wait_done(input string tag, input int max_cyc, output int busy_cycles);
        logic [7:0] held;
        bit         seen;
        bit         changed;
        seen        = 1'b0;
        changed     = 1'b0;
        busy_cycles = 0;
        held        = sum;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (sum !== held) changed = 1'b1;
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for done after %0d cycles", tag, max_cyc);
        end else begin
            check_result(tag);
        end
        check({tag, " sum_held_in_run"}, 32'(changed), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv, input exp_t e);
        int bc;
        @(negedge clk);
        a     = ta;
        b     = tbv;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // Operands must be ignored after the accepting edge.
        a     = 8'($urandom);
        b     = 8'($urandom);
        wait_done(tag, 20, bc);
        check({tag, " busy_cycles"}, 32'(bc), 32'd8);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'd0);
        check({tag, " carry_out"}, 32'(carry_out), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   n_done;
        int   bc;
        int   last_cyc;
        int   cyc;

        vecs[0] = '{a: 8'h0F, b: 8'h01, sum: 8'h10, co: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, co: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, co: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h80, b: 8'h80, sum: 8'h00, co: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 8'hAA, b: 8'h55, sum: 8'hFF, co: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'h00, b: 8'h00, sum: 8'h00, co: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, co: 1'b1, ovf: 1'b0};
        vecs[7] = '{a: 8'hC3, b: 8'h3C, sum: 8'hFF, co: 1'b0, ovf: 1'b0};
        vecs[8] = '{a: 8'h12, b: 8'h34, sum: 8'h46, co: 1'b0, ovf: 1'b0};
        vecs[9] = '{a: 8'h40, b: 8'h40, sum: 8'h80, co: 1'b0, ovf: 1'b1};

        // ---------------- reset ----------------
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d_%02h+%02h", i, vecs[i].a, vecs[i].b),
                  vecs[i].a, vecs[i].b, '{sum: vecs[i].sum, co: vecs[i].co, ovf: vecs[i].ovf});
        end

        // ---------------- start while busy is ignored ----------------
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        sb.push_back('{sum: 8'h03, co: 1'b0, ovf: 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a     = 8'h22;
        b     = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                n_done++;
                check_result("busy_start");
            end
            @(negedge clk);
        end
        check("busy_start done_count", 32'(n_done), 32'd1);
        check("busy_start sum_after", 32'(sum), 32'h03);

        // ---------------- reset in the middle of RUN ----------------
        @(negedge clk);
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset_now");
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("mid_reset done_count", 32'(n_done), 32'd0);
        check("mid_reset sum_after", 32'(sum), 32'd0);
        check("mid_reset busy_after", 32'(busy), 32'd0);

        // ---------------- start on first edge after reset ----------------
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a     = 8'h05;
        b     = 8'h03;
        start = 1'b1;
        sb.push_back('{sum: 8'h08, co: 1'b0, ovf: 1'b0});
        @(negedge clk);
        start = 1'b0;
        check("post_reset accepted", 32'(busy), 32'd1);
        wait_done("post_reset", 20, bc);
        check("post_reset busy_cycles", 32'(bc), 32'd8);

        // ---------------- start held high: one done every 10 cycles ----------
        @(negedge clk);
        @(negedge clk);
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        repeat (4) sb.push_back('{sum: 8'h02, co: 1'b0, ovf: 1'b0});
        n_done   = 0;
        last_cyc = 0;
        cyc      = 0;
        while (n_done < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check_result($sformatf("b2b%0d", n_done));
                if (n_done > 0) begin
                    check($sformatf("b2b%0d interval", n_done), 32'(cyc - last_cyc), 32'd10);
                end
                last_cyc = cyc;
                n_done++;
            end
        end
        start = 1'b0;
        check("b2b done_count", 32'(n_done), 32'd4);
        repeat (3) @(negedge clk);
        check("b2b idle_after", 32'(busy), 32'd0);

        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, inputs, WIDTH bits each: the operands, sampled on the clk edge that accepts start.
REQ-006 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse, high while in DONE.
REQ-008 The block SHALL have port sum, output, WIDTH bits: registered result of a+b modulo 2^WIDTH.
REQ-009 The block SHALL have port carry_out, output, 1 bit: registered carry out of the MSB.

Function
REQ-010 The block SHALL add bit-serially, LSB first, one bit per clk cycle, using a single 1-bit full adder built from two half-adder stages plus OR.
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL load a and b into shift registers, clear the internal carry and bit counter, and go to RUN.
REQ-013 In each RUN cycle, the block SHALL add shift-register bit 0 of each operand and the carry, shift the result bit in at the partial-sum MSB, register the new carry, and increment the counter.
REQ-014 After exactly WIDTH RUN cycles, the block SHALL go to DONE and load sum and carry_out from the partial-sum register and final carry on that same edge.
REQ-015 DONE SHALL last exactly one cycle, then the block SHALL return to IDLE unconditionally.
REQ-016 Latency: if start is accepted at edge N, the block SHALL assert done during the cycle following edge N+WIDTH.
REQ-017 The block SHALL ignore start in RUN and DONE, with no queuing.
REQ-018 The block SHALL accept start in the first IDLE cycle after DONE, so that back-to-back operations are separated by one IDLE cycle.
REQ-019 The block SHALL hold sum and carry_out stable from the DONE load until the next DONE load; they SHALL NOT change during RUN.
REQ-020 The block SHALL ignore changes on a and b after the accepting edge.
REQ-021 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-022 While rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, sum=0, carry_out=0, and clear all internal registers, independent of clk.
REQ-023 When reset is asserted mid-RUN, the block SHALL abandon the operation, produce no done pulse, and leave sum=0 afterwards.
REQ-024 On the first rising clk edge after rst_n deasserts, the block SHALL be able to accept start.

Configuration
REQ-025 When SERIAL_ADD_OVF_EN is defined, the block SHALL add output port ovf (1 bit), registered with sum, equal to (carry into MSB) XOR (carry out of MSB), i.e. two's-complement overflow.
REQ-026 The ovf port SHALL reset to 0 and follow the same hold rules as sum.
REQ-027 When SERIAL_ADD_OVF_EN is not defined, the block SHALL have no ovf port, no MSB carry-in capture logic, and otherwise identical behaviour.

Verification (WIDTH=8)
REQ-028 The bench SHALL drive a=0x0F, b=0x01, start for one cycle, and check busy=1 for 8 cycles, then done=1 for one cycle, with sum=0x10 and carry_out=0.
REQ-029 The bench SHALL drive a=0xFF, b=0x01, and check sum=0x00 and carry_out=1; with SERIAL_ADD_OVF_EN defined, check ovf=0.
REQ-030 With SERIAL_ADD_OVF_EN defined, the bench SHALL drive a=0x7F, b=0x01, and check sum=0x80, carry_out=0, ovf=1.
REQ-031 The bench SHALL pulse start with a=0x22, b=0x11 while busy=1 during an op of a=0x01, b=0x02, and check the single done pulse gives sum=0x03 with no second done.
REQ-032 The bench SHALL assert rst_n=0 mid-cycle at RUN cycle 4 of a=0xAA, b=0x55, and check all outputs are 0 immediately and no done pulse follows.
REQ-033 The bench SHALL hold start=1 continuously with constant a=0x01, b=0x01, and check a done pulse every 10 cycles, each with sum=0x02.
